// File: rtl/cpu_mul_scheduler_if.sv
// cpu_mul_scheduler_if
//   Request/response bundle between in-order decode and the multiply
//   issue/writeback scheduler.
//
//   master : decode side. Drives the multiply and ALU requests; observes
//            the ready/issue handshakes, writeback ownership, forwarding
//            flags and busy.
//   slave  : scheduler side (cpu_mul_scheduler).
//
//   Signals
//     mul_req_valid, mul_stage_wb, mul_rd_id/ra_id/rb_id : multiply request
//     alu_req_valid, alu_stage_wb, alu_rd_id/ra_id/rb_id : ALU request
//     mul_req_ready, mul_issue                           : multiply handshake
//     alu_req_ready                                      : ALU handshake
//     mul_wb_en, mul_wb_rd_id                            : retiring multiply
//     fwd_a, fwd_b                                       : bypass select
//     busy                                               : multiply in flight
interface cpu_mul_scheduler_if #(
  parameter int unsigned NUM_REGS = 16
);
  localparam int unsigned RID_W = $clog2(NUM_REGS);

  logic             mul_req_valid;
  logic             mul_stage_wb;
  logic [RID_W-1:0] mul_rd_id;
  logic [RID_W-1:0] mul_ra_id;
  logic [RID_W-1:0] mul_rb_id;
  logic             mul_req_ready;
  logic             mul_issue;

  logic             alu_req_valid;
  logic             alu_stage_wb;
  logic [RID_W-1:0] alu_rd_id;
  logic [RID_W-1:0] alu_ra_id;
  logic [RID_W-1:0] alu_rb_id;
  logic             alu_req_ready;

  logic             mul_wb_en;
  logic [RID_W-1:0] mul_wb_rd_id;
  logic             fwd_a;
  logic             fwd_b;
  logic             busy;

  modport master (
    output mul_req_valid, mul_stage_wb, mul_rd_id, mul_ra_id, mul_rb_id,
    output alu_req_valid, alu_stage_wb, alu_rd_id, alu_ra_id, alu_rb_id,
    input  mul_req_ready, mul_issue, alu_req_ready,
    input  mul_wb_en, mul_wb_rd_id, fwd_a, fwd_b, busy
  );

  modport slave (
    input  mul_req_valid, mul_stage_wb, mul_rd_id, mul_ra_id, mul_rb_id,
    input  alu_req_valid, alu_stage_wb, alu_rd_id, alu_ra_id, alu_rb_id,
    output mul_req_ready, mul_issue, alu_req_ready,
    output mul_wb_en, mul_wb_rd_id, fwd_a, fwd_b, busy
  );
endinterface

// File: rtl/cpu_mul_scheduler.sv
// cpu_mul_scheduler
//   Issue and writeback scheduler for a fixed-latency multiply pipeline.
//   Every multiply that writes a register is tracked in a shift-register
//   shadow scoreboard (one entry per pipeline stage). Requests are held on
//   RAW hazards against in-flight multiplies, ALU requests additionally on
//   WAW hazards and on collisions with the single register-file write port.
//
//   Parameters
//     MUL_STAGES : multiply latency in cycles (>= 2)
//     NUM_REGS   : architectural register count
//
//   Ports
//     clock : rising-edge clock
//     reset : asynchronous active-low reset; discards in-flight multiplies
//     bus   : cpu_mul_scheduler_if.slave request/response bundle
//
//   Build option
//     MUL_BYPASS_EN : when defined, the retiring entry is excluded from RAW
//                     checks and fwd_a/fwd_b select the retiring result for
//                     the accepted op. When undefined fwd_a/fwd_b are 0.
module cpu_mul_scheduler #(
  parameter int unsigned MUL_STAGES = 5,
  parameter int unsigned NUM_REGS   = 16
) (
  input logic               clock,
  input logic               reset,
  cpu_mul_scheduler_if.slave bus
);

  localparam int unsigned RID_W = $clog2(NUM_REGS);
  localparam int unsigned LAST  = MUL_STAGES - 1;

`ifdef MUL_BYPASS_EN
  // Retiring entry is forwarded, so it never causes a RAW stall.
  localparam int unsigned RAW_LAST = MUL_STAGES - 2;
`else
  localparam int unsigned RAW_LAST = MUL_STAGES - 1;
`endif

  if (MUL_STAGES < 2) begin : g_bad_depth
    $error("cpu_mul_scheduler: MUL_STAGES must be at least 2");
  end

  // Scoreboard: entry i holds a multiply issued i+1 cycles ago.
  logic             pend_v_q  [MUL_STAGES];
  logic [RID_W-1:0] pend_rd_q [MUL_STAGES];
  logic             pend_v_d  [MUL_STAGES];
  logic [RID_W-1:0] pend_rd_d [MUL_STAGES];

  logic mul_ra_hit;
  logic mul_rb_hit;
  logic alu_ra_hit;
  logic alu_rb_hit;
  logic alu_waw_hit;
  logic any_pend;
  logic mul_ready;
  logic mul_fire;
  logic alu_ready;
  logic alu_fire;
  logic fwd_a_d;
  logic fwd_b_d;

  // Hazard detection against the scoreboard.
  always_comb begin
    mul_ra_hit  = 1'b0;
    mul_rb_hit  = 1'b0;
    alu_ra_hit  = 1'b0;
    alu_rb_hit  = 1'b0;
    alu_waw_hit = 1'b0;
    any_pend    = 1'b0;

    for (int unsigned i = 0; i <= RAW_LAST; i++) begin
      if (pend_v_q[i]) begin
        if (pend_rd_q[i] == bus.mul_ra_id) mul_ra_hit = 1'b1;
        if (pend_rd_q[i] == bus.mul_rb_id) mul_rb_hit = 1'b1;
        if (pend_rd_q[i] == bus.alu_ra_id) alu_ra_hit = 1'b1;
        if (pend_rd_q[i] == bus.alu_rb_id) alu_rb_hit = 1'b1;
      end
    end

    // The retiring entry writes before an ALU accepted now, so it is not a
    // WAW hazard.
    for (int unsigned i = 0; i < LAST; i++) begin
      if (pend_v_q[i] && bus.alu_stage_wb && (pend_rd_q[i] == bus.alu_rd_id))
        alu_waw_hit = 1'b1;
    end

    for (int unsigned i = 0; i < MUL_STAGES; i++) begin
      if (pend_v_q[i]) any_pend = 1'b1;
    end
  end

  // Handshakes. Ready depends only on state and request ids; an ALU op is
  // refused whenever a multiply is presented (multiply has priority) and
  // whenever a multiply retires next cycle, since the ALU result would then
  // contend for the single write port.
  always_comb begin
    mul_ready = !mul_ra_hit && !mul_rb_hit;
    mul_fire  = bus.mul_req_valid && mul_ready;
    alu_ready = !alu_ra_hit && !alu_rb_hit && !alu_waw_hit &&
                !pend_v_q[LAST-1] && !bus.mul_req_valid;
    alu_fire  = bus.alu_req_valid && alu_ready;
  end

  // Operand forwarding from the retiring multiply to the op accepted now.
  always_comb begin
    fwd_a_d = 1'b0;
    fwd_b_d = 1'b0;
`ifdef MUL_BYPASS_EN
    if (pend_v_q[LAST]) begin
      if (mul_fire) begin
        fwd_a_d = (bus.mul_ra_id == pend_rd_q[LAST]);
        fwd_b_d = (bus.mul_rb_id == pend_rd_q[LAST]);
      end else if (alu_fire) begin
        fwd_a_d = (bus.alu_ra_id == pend_rd_q[LAST]);
        fwd_b_d = (bus.alu_rb_id == pend_rd_q[LAST]);
      end
    end
`endif
  end

  // Scoreboard shift. Multiplies without writeback never enter it.
  always_comb begin
    for (int unsigned i = 0; i < MUL_STAGES; i++) begin
      pend_v_d[i]  = 1'b0;
      pend_rd_d[i] = '0;
    end
    pend_v_d[0]  = mul_fire && bus.mul_stage_wb;
    pend_rd_d[0] = bus.mul_rd_id;
    for (int unsigned i = 1; i < MUL_STAGES; i++) begin
      pend_v_d[i]  = pend_v_q[i-1];
      pend_rd_d[i] = pend_rd_q[i-1];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < MUL_STAGES; i++) begin
        pend_v_q[i]  <= 1'b0;
        pend_rd_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < MUL_STAGES; i++) begin
        pend_v_q[i]  <= pend_v_d[i];
        pend_rd_q[i] <= pend_rd_d[i];
      end
    end
  end

  assign bus.mul_req_ready = mul_ready;
  assign bus.mul_issue     = mul_fire;
  assign bus.alu_req_ready = alu_ready;
  assign bus.mul_wb_en     = pend_v_q[LAST];
  assign bus.mul_wb_rd_id  = pend_rd_q[LAST];
  assign bus.fwd_a         = fwd_a_d;
  assign bus.fwd_b         = fwd_b_d;
  assign bus.busy          = any_pend;

endmodule

// File: tb/tb_cpu_mul_scheduler.sv
module tb_cpu_mul_scheduler;

  localparam int unsigned S = 5;
`ifdef MUL_BYPASS_EN
  localparam bit          BYP      = 1'b1;
  localparam int unsigned RAW_DONE = S;
`else
  localparam bit          BYP      = 1'b0;
  localparam int unsigned RAW_DONE = S + 1;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [3:0]  rd;
    int unsigned due;
  } wb_t;
  wb_t exp_q[$];
  wb_t mon_e;

  cpu_mul_scheduler_if #(.NUM_REGS(16)) bus ();

  cpu_mul_scheduler #(
    .MUL_STAGES(S),
    .NUM_REGS  (16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Writeback monitor: every retiring multiply must match the head of the
  // expectation queue, in rd and in cycle.
  always @(negedge clock) begin
    if (bus.mul_wb_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_wb cycle %0d: got rd %0d expected no writeback",
                 cyc, bus.mul_wb_rd_id);
      end else begin
        mon_e = exp_q.pop_front();
        chk4("wb_rd", bus.mul_wb_rd_id, mon_e.rd);
        chki("wb_cycle", int'(cyc), int'(mon_e.due));
      end
    end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
      mon_e = exp_q.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL missing_wb cycle %0d: got no writeback expected rd %0d", cyc, mon_e.rd);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    bus.mul_req_valid = 1'b0;
    bus.mul_stage_wb  = 1'b0;
    bus.mul_rd_id     = '0;
    bus.mul_ra_id     = '0;
    bus.mul_rb_id     = '0;
    bus.alu_req_valid = 1'b0;
    bus.alu_stage_wb  = 1'b0;
    bus.alu_rd_id     = '0;
    bus.alu_ra_id     = '0;
    bus.alu_rb_id     = '0;
  endtask

  task automatic mul(input logic [3:0] rd, input logic [3:0] ra, input logic [3:0] rb,
                     input logic wb);
    bus.mul_req_valid = 1'b1;
    bus.mul_stage_wb  = wb;
    bus.mul_rd_id     = rd;
    bus.mul_ra_id     = ra;
    bus.mul_rb_id     = rb;
  endtask

  task automatic alu(input logic [3:0] rd, input logic [3:0] ra, input logic [3:0] rb,
                     input logic wb);
    bus.alu_req_valid = 1'b1;
    bus.alu_stage_wb  = wb;
    bus.alu_rd_id     = rd;
    bus.alu_ra_id     = ra;
    bus.alu_rb_id     = rb;
  endtask

  task automatic drain();
    idle();
    repeat (S + 2) tick();
  endtask

  int unsigned a;

  initial begin
    idle();
    // Reset state
    #3;
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_wb_en", bus.mul_wb_en, 1'b0);
    chk4("rst_wb_rd", bus.mul_wb_rd_id, 4'd0);
    chk1("rst_fwd_a", bus.fwd_a, 1'b0);
    chk1("rst_fwd_b", bus.fwd_b, 1'b0);
    chk1("rst_mul_ready", bus.mul_req_ready, 1'b1);
    chk1("rst_alu_ready", bus.alu_req_ready, 1'b1);
    bus.mul_req_valid = 1'b1;
    #1;
    chk1("rst_alu_ready_mulv", bus.alu_req_ready, 1'b0);
    idle();
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Single multiply rd=3: busy 1..5, writeback in +5 only
    a = cyc;
    mul(4'd3, 4'd0, 4'd0, 1'b1);
    settle();
    chk1("t1_ready", bus.mul_req_ready, 1'b1);
    chk1("t1_issue", bus.mul_issue, 1'b1);
    chk1("t1_busy0", bus.busy, 1'b0);
    exp_q.push_back('{4'd3, a + S});
    tick();
    idle();
    for (int k = 1; k <= 6; k++) begin
      settle();
      chk1("t1_busy", bus.busy, (k <= 5));
      chk1("t1_wb_en", bus.mul_wb_en, (k == 5));
      if (k == 5) chk4("t1_wb_rd", bus.mul_wb_rd_id, 4'd3);
      tick();
    end

    // RAW: multiply rd=3, dependent multiply ra=3 held from next cycle
    a = cyc;
    mul(4'd3, 4'd1, 4'd1, 1'b1);
    settle();
    chk1("t2_prod_ready", bus.mul_req_ready, 1'b1);
    exp_q.push_back('{4'd3, a + S});
    tick();
    mul(4'd5, 4'd3, 4'd1, 1'b1);
    for (int unsigned k = 1; k <= RAW_DONE; k++) begin
      settle();
      chk1("t2_raw_ready", bus.mul_req_ready, (k == RAW_DONE));
      chk1("t2_fwd_a", bus.fwd_a, BYP && (k == RAW_DONE));
      chk1("t2_fwd_b", bus.fwd_b, 1'b0);
      if (k == RAW_DONE) exp_q.push_back('{4'd5, cyc + S});
      tick();
    end
    drain();

    // Write port collision: ALU held while multiply retires next cycle
    a = cyc;
    mul(4'd2, 4'd0, 4'd0, 1'b1);
    settle();
    chk1("t3_mul_ready", bus.mul_req_ready, 1'b1);
    exp_q.push_back('{4'd2, a + S});
    tick();
    idle();
    tick();
    tick();
    tick();
    alu(4'd7, 4'd1, 4'd1, 1'b1);
    settle();
    chk1("t3_alu_block", bus.alu_req_ready, 1'b0);
    chk1("t3_wb_en_c4", bus.mul_wb_en, 1'b0);
    tick();
    settle();
    chk1("t3_alu_accept", bus.alu_req_ready, 1'b1);
    chk1("t3_wb_en_c5", bus.mul_wb_en, 1'b1);
    chk4("t3_wb_rd", bus.mul_wb_rd_id, 4'd2);
    tick();
    drain();

    // WAW: ALU rd=4 held behind multiply rd=4
    a = cyc;
    mul(4'd4, 4'd0, 4'd0, 1'b1);
    exp_q.push_back('{4'd4, a + S});
    tick();
    idle();
    alu(4'd4, 4'd1, 4'd2, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      settle();
      chk1("t4_waw_ready", bus.alu_req_ready, (k == 5));
      tick();
    end
    drain();

    // No-writeback multiply leaves no hazard and never writes back
    mul(4'd4, 4'd0, 4'd0, 1'b0);
    settle();
    chk1("t5_nowb_issue", bus.mul_issue, 1'b1);
    tick();
    idle();
    alu(4'd9, 4'd4, 4'd4, 1'b1);
    settle();
    chk1("t5_alu_ready", bus.alu_req_ready, 1'b1);
    chk1("t5_busy", bus.busy, 1'b0);
    tick();
    drain();

    // ALU rd match without writeback is not WAW; source match is RAW
    a = cyc;
    mul(4'd4, 4'd0, 4'd0, 1'b1);
    exp_q.push_back('{4'd4, a + S});
    tick();
    idle();
    alu(4'd4, 4'd1, 4'd1, 1'b0);
    settle();
    chk1("t6_nowb_waw", bus.alu_req_ready, 1'b1);
    bus.alu_rb_id = 4'd4;
    #1;
    chk1("t6_alu_raw", bus.alu_req_ready, 1'b0);
    tick();
    drain();

    // Multiply priority, then back-to-back issue including same rd
    a = cyc;
    mul(4'd1, 4'd0, 4'd0, 1'b1);
    alu(4'd7, 4'd0, 4'd0, 1'b1);
    settle();
    chk1("t7_alu_yield", bus.alu_req_ready, 1'b0);
    chk1("t7_mul_ready0", bus.mul_req_ready, 1'b1);
    exp_q.push_back('{4'd1, a + S});
    tick();
    idle();
    mul(4'd6, 4'd0, 4'd0, 1'b1);
    settle();
    chk1("t7_mul_ready1", bus.mul_req_ready, 1'b1);
    exp_q.push_back('{4'd6, a + 1 + S});
    tick();
    mul(4'd6, 4'd0, 4'd0, 1'b1);
    settle();
    chk1("t7_mul_ready2", bus.mul_req_ready, 1'b1);
    exp_q.push_back('{4'd6, a + 2 + S});
    tick();
    drain();

    // Reset mid-flight discards both in-flight multiplies
    mul(4'd8, 4'd0, 4'd0, 1'b1);
    tick();
    mul(4'd9, 4'd0, 4'd0, 1'b1);
    tick();
    idle();
    settle();
    chk1("t8_busy_pre", bus.busy, 1'b1);
    reset = 1'b0;
    exp_q.delete();
    #1;
    chk1("t8_busy", bus.busy, 1'b0);
    chk1("t8_wb_en", bus.mul_wb_en, 1'b0);
    chk4("t8_wb_rd", bus.mul_wb_rd_id, 4'd0);
    mul(4'd8, 4'd8, 4'd9, 1'b1);
    #1;
    chk1("t8_mul_ready", bus.mul_req_ready, 1'b1);
    chk1("t8_alu_ready", bus.alu_req_ready, 1'b0);
    chk1("t8_fwd_a", bus.fwd_a, 1'b0);
    tick();
    tick();
    idle();
    reset = 1'b1;
    repeat (6) begin
      settle();
      chk1("t8_post_wb_en", bus.mul_wb_en, 1'b0);
      tick();
    end
    chki("t8_busy_after", int'(bus.busy), 0);

    chki("exp_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
